// File: rtl/shift_pkg.sv
// Shared types and constants for the shift arbiter and its barrel shifter.
package shift_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AMT_W = 4;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Operand captured on a grant and presented to the shifter.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic             dir;
        logic             id;
    } op_t;

endpackage

// File: rtl/barrel_shifter16.sv
// Combinational 16-bit logical barrel shifter, zero fill; shift_sel 1 = left.
module barrel_shifter16 (
    input  logic [15:0] i,
    input  logic        s0,
    input  logic        s1,
    input  logic        s2,
    input  logic        s3,
    input  logic        shift_sel,
    output logic [15:0] o
);

    logic [15:0] st1;
    logic [15:0] st2;
    logic [15:0] st3;

    // Four binary-weighted stages: 1, 2, 4, 8.
    always_comb begin
        st1 = i;
        if (s0) st1 = shift_sel ? {i[14:0], 1'b0} : {1'b0, i[15:1]};
        st2 = st1;
        if (s1) st2 = shift_sel ? {st1[13:0], 2'b00} : {2'b00, st1[15:2]};
        st3 = st2;
        if (s2) st3 = shift_sel ? {st2[11:0], 4'h0} : {4'h0, st2[15:4]};
        o = st3;
        if (s3) o = shift_sel ? {st3[7:0], 8'h00} : {8'h00, st3[15:8]};
    end

endmodule

// File: rtl/shift_arbiter2.sv
// Round-robin arbiter/sequencer sharing one barrel_shifter16 between two
// requesters, with a one-entry registered response holding stage.
module shift_arbiter2 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic [AMT_W-1:0] a_amt,
    input  logic             a_dir,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic [AMT_W-1:0] b_amt,
    input  logic             b_dir,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);
    import shift_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic             prio_q;
    op_t              op_q;
    op_t              op_sel_c;
    logic             pick_b_c;
    logic             grant_c;
    logic [WIDTH-1:0] shift_out;

    // Pick: B wins if it is the only one valid, or both are valid and prio favours B.
    always_comb begin
        pick_b_c = b_valid & (~a_valid | prio_q);
        grant_c  = (state_q == S_IDLE) & (a_valid | b_valid);
        op_sel_c.data = pick_b_c ? b_data : a_data;
        op_sel_c.amt  = pick_b_c ? b_amt  : a_amt;
        op_sel_c.dir  = pick_b_c ? b_dir  : a_dir;
        op_sel_c.id   = pick_b_c ? ID_B   : ID_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (a_valid | b_valid) state_d = S_SHIFT;
            S_SHIFT: state_d = S_HOLD;
            S_HOLD:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Readys are only ever asserted for the current IDLE-cycle winner.
    always_comb begin
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                a_ready = a_valid & ~pick_b_c;
                b_ready = pick_b_c;
            end
            S_HOLD:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and arbitration pointer update on grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            prio_q <= 1'b0;
        end else if (grant_c) begin
            op_q   <= op_sel_c;
            prio_q <= ~pick_b_c;
        end
    end

    barrel_shifter16 u_shifter (
        .i         (op_q.data),
        .s0        (op_q.amt[0]),
        .s1        (op_q.amt[1]),
        .s2        (op_q.amt[2]),
        .s3        (op_q.amt[3]),
        .shift_sel (op_q.dir),
        .o         (shift_out)
    );

    // Result register loads only in SHIFT, so it stays stable through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else if (state_q == S_SHIFT) begin
            rsp_data <= shift_out;
            rsp_id   <= op_q.id;
        end
    end

endmodule

// File: tb/tb_shift_arbiter2.sv
// Scoreboard bench for shift_arbiter2: cycle model of arbitration plus queue of expected results.
module tb_shift_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, a_dir, b_dir, rsp_ready;
    logic [15:0] a_data, b_data;
    logic [3:0]  a_amt, b_amt;
    logic        a_ready, b_ready, rsp_valid, rsp_id;
    logic [15:0] rsp_data;

    typedef struct {
        logic [15:0] data;
        logic        id;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          m_state;
    logic        m_prio;
    bit          auto_drop;

    shift_arbiter2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_amt     (a_amt),
        .a_dir     (a_dir),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_amt     (b_amt),
        .b_dir     (b_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] amt,
                                              input logic dir);
        return dir ? (d << amt) : (d >> amt);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_prio  = 1'b0;
        sb_q.delete();
    endtask

    // Called right after a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        logic win;
        logic fire_a;
        logic fire_b;
        exp_t e;
        #1;
        win    = 1'b0;
        fire_a = 1'b0;
        fire_b = 1'b0;
        if (m_state == 0 && (a_valid || b_valid)) begin
            win    = (a_valid && b_valid) ? m_prio : b_valid;
            fire_a = ~win;
            fire_b = win;
        end
        check("a_ready", 32'(a_ready), 32'(fire_a));
        check("b_ready", 32'(b_ready), 32'(fire_b));
        check("rsp_valid", 32'(rsp_valid), 32'(m_state == 2));
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                check("rsp_data", 32'(rsp_data), 32'(sb_q[0].data));
                check("rsp_id", 32'(rsp_id), 32'(sb_q[0].id));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
        case (m_state)
            0: if (fire_a || fire_b) begin
                e.id   = win;
                e.data = win ? ref_shift(b_data, b_amt, b_dir) : ref_shift(a_data, a_amt, a_dir);
                sb_q.push_back(e);
                m_prio  = ~win;
                m_state = 1;
            end
            1: m_state = 2;
            default: if (rsp_ready) m_state = 0;
        endcase
        @(negedge clk);
        if (auto_drop) begin
            if (fire_a) a_valid = 1'b0;
            if (fire_b) b_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (m_state == 0 && !a_valid && !b_valid && sb_q.size() == 0) return;
            tick();
        end
        check("drain_timeout", 32'(sb_q.size()), 32'(0));
        check("drain_state", 32'(m_state), 32'(0));
    endtask

    task automatic set_a(input logic [15:0] d, input logic [3:0] amt, input logic dir);
        a_data = d; a_amt = amt; a_dir = dir; a_valid = 1'b1;
    endtask

    task automatic set_b(input logic [15:0] d, input logic [3:0] amt, input logic dir);
        b_data = d; b_amt = amt; b_dir = dir; b_valid = 1'b1;
    endtask

    // Asynchronous reset from a falling edge; releases at the next falling edge.
    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(rsp_data), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] edge_d[5]   = '{16'hFFFF, 16'h0000, 16'h1234, 16'h8421, 16'h0001};
    logic [3:0]  edge_amt[5] = '{4'd8, 4'd3, 4'd0, 4'd0, 4'd15};
    logic        edge_dir[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
        a_data = '0; a_amt = '0; a_dir = 1'b0;
        b_data = '0; b_amt = '0; b_dir = 1'b0;
        auto_drop = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_a_ready", 32'(a_ready), 32'(0));
        check("reset_b_ready", 32'(b_ready), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_data", 32'(rsp_data), 32'(0));
        check("reset_rsp_id", 32'(rsp_id), 32'(0));
        rst_n = 1'b1;

        // Single A request: A861 << 8 = 6100, two cycles after the grant.
        rsp_ready = 1'b1;
        set_a(16'hA861, 4'd8, 1'b1);
        drain();

        // Simultaneous requests held valid from reset: A, B, A alternation.
        @(negedge clk);
        reset_now();
        auto_drop = 1'b0;
        set_a(16'hCE39, 4'd3, 1'b0);
        set_b(16'h0001, 4'd15, 1'b1);
        repeat (8) tick();
        a_valid = 1'b0; b_valid = 1'b0;
        auto_drop = 1'b1;
        drain();

        // Backpressure: B result held 5+ cycles while A waits.
        rsp_ready = 1'b0;
        set_b(16'hD70F, 4'd12, 1'b1);
        repeat (2) tick();
        set_a(16'h1234, 4'd4, 1'b1);
        repeat (6) tick();
        rsp_ready = 1'b1;
        drain();

        // Edge shift amounts.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) set_a(edge_d[i], edge_amt[i], edge_dir[i]);
            else            set_b(edge_d[i], edge_amt[i], edge_dir[i]);
            drain();
        end

        // Reset in SHIFT after an A grant; prio must come back to A.
        set_a(16'h5555, 4'd2, 1'b1);
        tick();
        set_a(16'h00FF, 4'd4, 1'b1);
        set_b(16'h00F0, 4'd4, 1'b0);
        reset_now();
        drain();

        // Reset while a result is held; a lone pending B is granted at the first edge.
        rsp_ready = 1'b0;
        set_a(16'h0F0F, 4'd1, 1'b0);
        repeat (3) tick();
        set_b(16'hC003, 4'd1, 1'b0);
        reset_now();
        rsp_ready = 1'b1;
        drain();

        // Withdrawn A request: raised while busy, dropped before IDLE; only B is served.
        set_b(16'h0F0F, 4'd4, 1'b0);
        tick();
        set_a(16'hBEEF, 4'd1, 1'b1);
        tick();
        a_valid = 1'b0;
        set_b(16'h3C3C, 4'd2, 1'b1);
        tick();
        drain();

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
